multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_pkg.sv | 47 ++++
 rtl/rv_opcode_decode.sv | 39 +++
 rtl/multicycle_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle control unit:
// FSM states, RV32 base opcodes, jump/result_src encodings, decode bundle.
package multicycle_control_unit_pkg;

    localparam int unsigned OPC_W = 7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // Everything the FSM needs to know about the latched opcode.
    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       branch;
        logic       alu_src_b;
        logic [1:0] jump;
        logic       auipc;
        logic [1:0] result_src;
    } dec_t;

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational opcode decoder: legality plus datapath controls.
// Illegal opcodes decode like an immediate ALU op so they can run as NOPs.
module rv_opcode_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        dec            = '0;
        dec.legal      = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.jump       = JUMP_NONE;
        dec.result_src = RES_ALU;
        case (opcode)
            OP_R:      dec.alu_src_b = 1'b0;
            OP_IMM:    dec.auipc = 1'b0;
            OP_LOAD: begin
                dec.is_load    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE:  dec.is_store = 1'b1;
            OP_BRANCH: dec.branch = 1'b1;
            OP_LUI:    dec.result_src = RES_IMM;
            OP_AUIPC:  dec.auipc = 1'b1;
            OP_JAL: begin
                dec.jump       = JUMP_JAL;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.jump       = JUMP_JALR;
                dec.result_src = RES_PC4;
            end
            default:   dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing,
// memory wait timeout, stall freeze, sticky trap and retired-instruction count.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRAP_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  instr,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             branch,
    output logic [1:0]       jump,
    output logic             alu_src_b,
    output logic [1:0]       result_src,
    output logic             auipc,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q;
    logic               illegal_q;
    logic               retire;
    logic               waiting;
    dec_t               dec;
    logic               unused_instr_hi;

    assign unused_instr_hi = ^instr[XLEN-1:OPC_W];

    rv_opcode_decode u_decode (
        .opcode (opcode_q),
        .dec    (dec)
    );

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            opcode_q  <= OP_IMM;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_d == TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next state and control outputs; stall and reset override at the end.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_d     = wait_q;
        retire     = 1'b0;
        waiting    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump       = JUMP_NONE;
        alu_src_b  = 1'b0;
        result_src = RES_ALU;
        auipc      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    opcode_d = instr[OPC_W-1:0];
                    state_d  = DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                state_d = (!dec.legal && TRAP_EN != 0) ? TRAP : EXEC;
            end
            EXEC: begin
                alu_src_b = dec.alu_src_b;
                branch    = dec.branch;
                jump      = dec.jump;
                auipc     = dec.auipc;
                if (dec.is_load || dec.is_store) begin
                    state_d = MEM;
                end else if (dec.branch) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = dec.is_store;
                if (mem_ready) begin
                    if (dec.is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                result_src = dec.result_src;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // The wait that completes the MEM_TIMEOUT-th missed cycle traps;
        // mem_ready in the same cycle takes the normal path instead.
        if (waiting && MEM_TIMEOUT != 0 && TRAP_EN != 0 &&
            (wait_q + WAIT_W'(1)) == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = TRAP;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && wait_q != '1) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        if (stall) begin
            state_d   = state_q;
            opcode_d  = opcode_q;
            wait_d    = wait_q;
            retire    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
        end

        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4, CNT_W=4, TRAP_EN=1).
module tb_multicycle_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        branch;
    logic [1:0]  jump;
    logic        alu_src_b;
    logic [1:0]  result_src;
    logic        auipc;
    logic [2:0]  state;
    logic        illegal;
    logic [3:0]  instret;

    int vectors;
    int miscompares;

    multicycle_control_unit #(
        .XLEN        (32),
        .MEM_TIMEOUT (4),
        .CNT_W       (4),
        .TRAP_EN     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .branch     (branch),
        .jump       (jump),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .auipc      (auipc),
        .state      (state),
        .illegal    (illegal),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        instr       = 32'h0;
        mem_ready   = 1'b0;
        stall       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("fetch_mem_req", 32'(mem_req), 32'd1);

        // Stall in FETCH beats mem_ready
        stall     = 1'b1;
        mem_ready = 1'b1;
        instr     = 32'h002081B3;
        #1;
        chk("stall_f_mem_req", 32'(mem_req), 32'd0);
        chk("stall_f_ir_write", 32'(ir_write), 32'd0);
        tick();
        chk("stall_f_state", 32'(state), 32'd0);

        // R-type: 0,1,2,4,0
        stall = 1'b0;
        #1;
        chk("r_ir_write", 32'(ir_write), 32'd1);
        chk("r_c1_reg_write", 32'(reg_write), 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("r_c2_state", 32'(state), 32'd1);
        chk("r_c2_reg_write", 32'(reg_write), 32'd0);
        tick();
        chk("r_c3_state", 32'(state), 32'd2);
        chk("r_alu_src_b", 32'(alu_src_b), 32'd0);
        chk("r_c3_reg_write", 32'(reg_write), 32'd0);
        tick();
        chk("r_c4_state", 32'(state), 32'd4);
        chk("r_c4_reg_write", 32'(reg_write), 32'd1);
        chk("r_c4_pc_write", 32'(pc_write), 32'd1);
        chk("r_result_src", 32'(result_src), 32'd0);
        tick();
        chk("r_end_state", 32'(state), 32'd0);
        chk("r_instret", 32'(instret), 32'd1);
        chk("r_end_reg_write", 32'(reg_write), 32'd0);

        // Load with 3 wait cycles: F D E M M M M W
        instr     = 32'h0000A183;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("ld_alu_src_b", 32'(alu_src_b), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_state", 32'(state), 32'd3);
            chk("ld_wait_mem_req", 32'(mem_req), 32'd1);
            chk("ld_wait_mem_we", 32'(mem_we), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_m4_state", 32'(state), 32'd3);
        chk("ld_m4_mem_req", 32'(mem_req), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("ld_wb_state", 32'(state), 32'd4);
        chk("ld_result_src", 32'(result_src), 32'd1);
        chk("ld_reg_write", 32'(reg_write), 32'd1);
        tick();
        chk("ld_end_state", 32'(state), 32'd0);
        chk("ld_instret", 32'(instret), 32'd2);

        // Branch with a 3-cycle stall in EXEC
        instr     = 32'h00000063;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_e_state", 32'(state), 32'd2);
            chk("stall_e_pc_write", 32'(pc_write), 32'd0);
            chk("stall_e_branch", 32'(branch), 32'd1);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("br_state", 32'(state), 32'd2);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("br_end_state", 32'(state), 32'd0);
        chk("br_instret", 32'(instret), 32'd3);

        // Store, memory never ready: TRAP after 4 wait cycles
        instr     = 32'h0020A023;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_wait_state", 32'(state), 32'd3);
            chk("st_wait_mem_req", 32'(mem_req), 32'd1);
            chk("st_wait_mem_we", 32'(mem_we), 32'd1);
            tick();
        end
        chk("st_to_state", 32'(state), 32'd5);
        chk("st_to_illegal", 32'(illegal), 32'd1);
        chk("st_to_mem_req", 32'(mem_req), 32'd0);
        chk("st_to_instret", 32'(instret), 32'd3);
        mem_ready = 1'b1;
        tick();
        chk("trap_hold_state", 32'(state), 32'd5);
        chk("trap_hold_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;

        // Reset exits TRAP
        rst_n = 1'b0;
        #1;
        chk("rst_low_mem_req", 32'(mem_req), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_illegal", 32'(illegal), 32'd0);
        chk("trap_rst_instret", 32'(instret), 32'd0);
        chk("trap_rst_mem_req", 32'(mem_req), 32'd1);

        // Reset during a load wait: no retire, fetch restarts
        instr     = 32'h0000A183;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_ld_state", 32'(state), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_instret", 32'(instret), 32'd0);
        chk("mid_rst_illegal", 32'(illegal), 32'd0);
        chk("mid_rst_mem_req", 32'(mem_req), 32'd1);

        // Illegal opcode traps after DECODE
        instr     = 32'h0000007F;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("ill_dec_state", 32'(state), 32'd1);
        tick();
        chk("ill_state", 32'(state), 32'd5);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_mem_req", 32'(mem_req), 32'd0);
        tick();
        tick();
        chk("ill_hold_state", 32'(state), 32'd5);
        chk("ill_hold_mem_req", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;

        // 17 branches on a 4-bit counter wrap to 1
        for (int i = 0; i < 17; i++) begin
            instr     = 32'h00000063;
            mem_ready = 1'b1;
            #1;
            tick();
            mem_ready = 1'b0;
            tick();
            tick();
        end
        chk("wrap_state", 32'(state), 32'd0);
        chk("wrap_instret", 32'(instret), 32'd1);

        // JAL
        instr     = 32'h0000006F;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("jal_jump", 32'(jump), 32'd1);
        chk("jal_alu_src_b", 32'(alu_src_b), 32'd1);
        tick();
        chk("jal_wb_state", 32'(state), 32'd4);
        chk("jal_result_src", 32'(result_src), 32'd2);
        tick();
        chk("jal_instret", 32'(instret), 32'd2);

        // Store, zero wait: 4 cycles
        instr     = 32'h0020A023;
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        chk("st_mem_state", 32'(state), 32'd3);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_pc_write", 32'(pc_write), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("st_end_state", 32'(state), 32'd0);
        chk("st_instret", 32'(instret), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
